// File: rtl/wdt.sv
// MMIO watchdog core: armed by firmware or app, kicked with a magic word, and raises a sticky
// level `expired` toward tk1 when the tick counter runs out.
module wdt #(
  parameter logic [31:0] DEFAULT_TIMEOUT   = 32'h0100_0000,
  parameter logic [31:0] DEFAULT_PRESCALER = 32'd18000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        fw_app_mode_i,
  input  logic        cs_i,
  input  logic        we_i,
  input  logic [7:0]  address_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  output logic        ready_o,
  output logic        expired_o
);

  localparam logic [7:0]  AddrName0     = 8'h00;
  localparam logic [7:0]  AddrName1     = 8'h01;
  localparam logic [7:0]  AddrVersion   = 8'h02;
  localparam logic [7:0]  AddrCtrl      = 8'h08;
  localparam logic [7:0]  AddrStatus    = 8'h09;
  localparam logic [7:0]  AddrTimeout   = 8'h0a;
  localparam logic [7:0]  AddrKick      = 8'h0b;
  localparam logic [7:0]  AddrCount     = 8'h0c;
  localparam logic [7:0]  AddrPrescaler = 8'h0d;

  localparam logic [31:0] Name0Val   = 32'h7764_7420;
  localparam logic [31:0] Name1Val   = 32'h746b_3120;
  localparam logic [31:0] VersionVal = 32'h0000_0001;
  localparam logic [31:0] KickMagic  = 32'h4b49_434b;

  typedef enum logic [1:0] {StStopped, StRunning, StExpired} state_e;

  state_e      state_q, state_d;
  logic [31:0] timeout_q, timeout_d;
  logic [31:0] prescaler_q, prescaler_d;
  logic [31:0] count_q, count_d;
  logic [31:0] presc_cnt_q, presc_cnt_d;
  logic        expired_q, expired_d;
  logic        ready_q;
  logic [31:0] read_data_q, rdata;

  logic wr_en, start, stop, kick, cfg_ok, tick;

  // cs is held for two cycles; only the first edge of an access performs the write.
  assign wr_en  = cs_i && we_i && !ready_q;
  assign start  = wr_en && (address_i == AddrCtrl) && write_data_i[0];
  assign stop   = wr_en && (address_i == AddrCtrl) && write_data_i[1];
  assign kick   = wr_en && (address_i == AddrKick) && (write_data_i == KickMagic);
  assign cfg_ok = (state_q == StStopped) && !fw_app_mode_i;
  assign tick   = (presc_cnt_q == prescaler_q);

  always_comb begin
    timeout_d   = timeout_q;
    prescaler_d = prescaler_q;
    if (wr_en && cfg_ok && (address_i == AddrTimeout))   timeout_d   = write_data_i;
    if (wr_en && cfg_ok && (address_i == AddrPrescaler)) prescaler_d = write_data_i;
  end

  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    presc_cnt_d = presc_cnt_q;
    case (state_q)
      StStopped: begin
        if (start && !stop) begin
          state_d     = StRunning;
          count_d     = timeout_q;
          presc_cnt_d = '0;
        end
      end
      StRunning: begin
        presc_cnt_d = tick ? '0 : presc_cnt_q + 32'd1;
        if (stop && !fw_app_mode_i) begin
          state_d = StStopped;
        end else if (kick) begin
          // A kick wins over a coincident tick, including the one that would expire.
          count_d     = timeout_q;
          presc_cnt_d = '0;
        end else if (tick) begin
          if (count_q != '0) count_d = count_q - 32'd1;
          else               state_d = StExpired;
        end
      end
      StExpired: begin
        if (stop && !fw_app_mode_i) state_d = StStopped;
      end
      default: state_d = StStopped;
    endcase
  end

  // Rises the cycle after entering EXPIRED and clears on the same edge as the leaving STOP.
  assign expired_d = (state_q == StExpired) && (state_d == StExpired);

  always_comb begin
    rdata = '0;
    case (address_i)
      AddrName0:     rdata = Name0Val;
      AddrName1:     rdata = Name1Val;
      AddrVersion:   rdata = VersionVal;
      AddrStatus:    rdata = {30'b0, expired_q, state_q == StRunning};
      AddrTimeout:   rdata = timeout_q;
      AddrCount:     rdata = count_q;
      AddrPrescaler: rdata = prescaler_q;
      default:       rdata = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state_q     <= StStopped;
      timeout_q   <= DEFAULT_TIMEOUT;
      prescaler_q <= DEFAULT_PRESCALER;
      count_q     <= '0;
      presc_cnt_q <= '0;
      expired_q   <= 1'b0;
      ready_q     <= 1'b0;
      read_data_q <= '0;
    end else begin
      state_q     <= state_d;
      timeout_q   <= timeout_d;
      prescaler_q <= prescaler_d;
      count_q     <= count_d;
      presc_cnt_q <= presc_cnt_d;
      expired_q   <= expired_d;
      ready_q     <= cs_i;
      read_data_q <= cs_i ? rdata : '0;
    end
  end

  assign read_data_o = read_data_q;
  assign ready_o     = ready_q;
  assign expired_o   = expired_q;

endmodule

// File: doc/wdt.md
Name: wdt

Overview:
- MMIO watchdog core on the CPU bus, decoded under its own core sub-prefix alongside timer/uart/tk1.
- Standard core handshake toward the top-level decode mux: cs/we/address/write_data in, read_data/ready out.
- Firmware or the app arms it; the app must kick it with a magic word before timeout.
- On expiry, the level output `expired` is routed to tk1, which asserts force_trap so the CPU traps.

Parameters:
DEFAULT_TIMEOUT, 32'h0100_0000, reset value of TIMEOUT register (ticks)
DEFAULT_PRESCALER, 32'd18000, reset value of PRESCALER register (clk cycles per tick minus 1)

Ports:
clk  input  1  system clock
reset_n  input  1  reset, synchronous, active-low
fw_app_mode  input  1  1 = app mode; locks STOP and config writes
cs  input  1  core select from bus decode; held until mux sees ready
we  input  1  write enable (|cpu_wstrb)
address  input  8  word address (cpu_addr[9:2])
write_data  input  32  write data
read_data  output  32  read data, valid when ready=1
ready  output  1  access complete
expired  output  1  watchdog expired, level, sticky

Behaviour:
- Reset: read_data=0, ready=0, expired=0, state=STOPPED, TIMEOUT=DEFAULT_TIMEOUT, PRESCALER=DEFAULT_PRESCALER, count=0, prescale counter=0.
- Handshake:
  - ready_reg <= cs each cycle, so ready rises 1 cycle after cs and drops the cycle after cs drops.
  - read_data is registered in the same cycle as ready_reg.
  - Writes take effect only on the edge where cs && we && !ready_reg, so exactly once per access even though cs is held 2 cycles.
  - Unmapped addresses: reads return 0, writes are ignored, ready behaves the same.
- Register map (word address):
  - 0x00 NAME0 RO "wdt " (32'h7764_7420).
  - 0x01 NAME1 RO "tk1 " (32'h746b_3120).
  - 0x02 VERSION RO 32'h0000_0001.
  - 0x08 CTRL WO: bit0 START, bit1 STOP.
  - 0x09 STATUS RO: bit0 running, bit1 expired.
  - 0x0a TIMEOUT RW.
  - 0x0b KICK WO: effective only if write_data == 32'h4b49_434b ("KICK").
  - 0x0c COUNT RO: current count.
  - 0x0d PRESCALER RW.
- TIMEOUT and PRESCALER writes are ignored when state != STOPPED or fw_app_mode=1.
- States:
  - STOPPED:
    - START -> RUNNING; count <= TIMEOUT; prescale counter <= 0.
  - RUNNING:
    - Prescale counter increments each cycle; when it equals PRESCALER it wraps to 0 and emits a tick (PRESCALER=0 gives a tick every cycle).
    - On a tick with count != 0: count <= count-1.
    - On a tick with count == 0: -> EXPIRED.
    - Valid KICK: count <= TIMEOUT and prescale counter <= 0.
    - STOP with fw_app_mode=0: -> STOPPED, count held. STOP with fw_app_mode=1 is ignored.
    - START is ignored.
  - EXPIRED:
    - expired=1 (registered, asserted the cycle after the transition); count stays 0.
    - KICK and START are ignored.
    - STOP with fw_app_mode=0: -> STOPPED, expired<=0.
    - Otherwise exits only via reset.
- Simultaneous events:
  - KICK on a tick cycle: KICK wins, including the cycle that would expire.
  - START and STOP in one write: STOP wins.
  - START with TIMEOUT=0: RUNNING, then EXPIRED on the first tick.
- Width rules: all counters are 32-bit unsigned. count never wraps below 0. The prescale counter compares by equality.
- Reset mid-operation: all state returns to reset values on the next edge; no pending access completes (ready=0).
- fw_app_mode changing while RUNNING: takes effect immediately for subsequent STOP writes.

Test Plan:
- Reset, then read 0x00/0x01/0x02 -> 32'h7764_7420, 32'h746b_3120, 32'h0000_0001. ready goes high exactly 1 cycle after cs. expired=0.
- fw_app_mode=0, PRESCALER=0, TIMEOUT=5, CTRL=1:
  - COUNT reads 5,4,...,0 on successive cycles.
  - The transition to EXPIRED occurs on the tick 6 cycles after START; expired rises 1 cycle after that.
  - STATUS=2'b10.
- TIMEOUT=3, PRESCALER=0, START; then every 3 cycles write KICK=32'h4b49_434b for 50 cycles -> expired stays 0.
  - A KICK with data 32'h0 -> ignored; expired follows.
  - A valid KICK on the expiring tick -> count=3, no expiry.
- fw_app_mode=1, RUNNING: write CTRL=2 -> still running; write TIMEOUT=7 -> reads the old value.
  - Then fw_app_mode=0, CTRL=2 -> STOPPED, STATUS=0.
- PRESCALER=3, TIMEOUT=2, START -> count decrements every 4 cycles; expired asserted 12 cycles after START plus the 1-cycle registered output.
- Assert reset_n=0 for 1 cycle while EXPIRED and mid-access -> expired=0, ready=0, TIMEOUT reads 32'h0100_0000.
